disp16: RTL

DISP16 -- requirements
Module: disp16

---
 rtl/disp16_pkg.sv | 15 +
 rtl/rr_pick16.sv | 26 ++
 rtl/disp16.sv | 98 +++++++++
 3 files changed

// File: rtl/disp16_pkg.sv
// Shared definitions for the 16-channel round-robin dispatcher:
// FSM state encoding and the default completion timeout.
package disp16_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEARCH = 2'd1,
    S_ISSUE  = 2'd2,
    S_WAIT   = 2'd3
  } state_t;

  localparam int TIMEOUT_DEFAULT = 255;
  localparam int CNT_W           = 8;

endpackage

// File: rtl/rr_pick16.sv
// Combinational round-robin picker: first eligible channel at or after ptr,
// wrapping 15 -> 0.
module rr_pick16 (
  input  logic [15:0] eligible,
  input  logic [3:0]  ptr,
  output logic        found,
  output logic [3:0]  idx
);

  logic [3:0] cand;

  // Scan from the farthest offset down so the nearest eligible index wins.
  always_comb begin
    found = 1'b0;
    idx   = 4'd0;
    cand  = 4'd0;
    for (int k = 15; k >= 0; k--) begin
      cand = ptr + 4'(k);
      if (eligible[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/disp16.sv
// Round-robin request dispatcher over 16 channels with per-dispatch
// completion tracking and a completion timeout.
module disp16
  import disp16_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  output logic        ack,
  input  logic [15:0] en,
  input  logic [15:0] busy,
  input  logic [15:0] done,
  output logic [15:0] strb,
  output logic [3:0]  chan,
  output logic        idle,
  output logic        err
);

  state_t             state, state_nxt;
  logic [3:0]         ptr;
  logic [CNT_W-1:0]   cnt;
  logic               pick_found;
  logic [3:0]         pick_idx;
  logic               take, hit, expire;
  logic [15:0]        strb_nxt;
  logic               ack_nxt, err_nxt, idle_nxt;

  rr_pick16 u_pick (
    .eligible (en & ~busy),
    .ptr      (ptr),
    .found    (pick_found),
    .idx      (pick_idx)
  );

  assign take   = (state == S_SEARCH) && req && pick_found;
  assign hit    = done[chan];
  assign expire = (cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (req) state_nxt = S_SEARCH;
      S_SEARCH: begin
        if (!req)           state_nxt = S_IDLE;
        else if (pick_found) state_nxt = S_ISSUE;
      end
      S_ISSUE:  state_nxt = S_WAIT;
      S_WAIT:   if (hit || expire) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded one cycle early and registered, so strb/ack line up
  // with the ISSUE state and err/idle with the return to IDLE.
  always_comb begin
    strb_nxt = take ? (16'd1 << pick_idx) : 16'd0;
    ack_nxt  = take;
    err_nxt  = (state == S_WAIT) && !hit && expire;
    idle_nxt = (state_nxt == S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      strb <= 16'd0;
      ack  <= 1'b0;
      err  <= 1'b0;
      idle <= 1'b1;
    end else begin
      strb <= strb_nxt;
      ack  <= ack_nxt;
      err  <= err_nxt;
      idle <= idle_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr  <= 4'd0;
      chan <= 4'd0;
      cnt  <= '0;
    end else begin
      if (take) chan <= pick_idx;
      if (state == S_ISSUE) cnt <= '0;
      if (state == S_WAIT) begin
        if (hit || expire) ptr <= chan + 4'd1;
        else               cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule
